// File: rtl/cram_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared CRAM port, bundled for the arbiter.
// Requester i uses slice i of every packed per-requester vector.
interface cram_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*BE_W-1:0]   req_be;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_err;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;

  logic                      mem_req;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [BE_W-1:0]           mem_be;
  logic                      mem_ack;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, req_lock,
    input  mem_ack, mem_rdata,
    output req_ack, req_err, req_rdata, grant, busy,
    output mem_req, mem_write, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, req_lock,
    output mem_ack, mem_rdata,
    input  req_ack, req_err, req_rdata, grant, busy,
    input  mem_req, mem_write, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/cram_port_arbiter.sv
// Round-robin arbiter sharing one CRAM port between NUM_REQ requesters, with an
// owner lock for back-to-back bursts and a watchdog that aborts hung transactions.
module cram_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset_n,
  cram_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   start_q;
  logic [IDX_W-1:0]   owner_q;
  logic               lock_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mem_req_q;
  logic               mem_write_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [BE_W-1:0]    mem_be_q;
  logic [NUM_REQ-1:0] req_ack_q;
  logic [NUM_REQ-1:0] req_err_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [DATA_W-1:0]  req_rdata_q;
  logic               busy_q;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [IDX_W-1:0]   sel_next;

  // A locked previous owner that is still requesting overrides the rotating search.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(start_q) + i) % NUM_REQ);
      if (!sel_found && bus.req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
    if (lock_q && bus.req_valid[owner_q]) begin
      sel_found = 1'b1;
      sel_idx   = owner_q;
    end
    sel_onehot = NUM_REQ'(1) << sel_idx;
    sel_next   = (int'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      start_q     <= '0;
      owner_q     <= '0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      req_ack_q   <= '0;
      req_err_q   <= '0;
      grant_q     <= '0;
      req_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      req_ack_q <= '0;
      req_err_q <= '0;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            mem_req_q   <= 1'b1;
            mem_write_q <= bus.req_write[sel_idx];
            mem_addr_q  <= bus.req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            mem_wdata_q <= bus.req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
            mem_be_q    <= bus.req_be[int'(sel_idx)*BE_W +: BE_W];
            grant_q     <= sel_onehot;
            owner_q     <= sel_idx;
            start_q     <= sel_next;
            cnt_q       <= CNT_W'(1);
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        // A real acknowledge takes precedence over a watchdog expiry in the same cycle.
        ISSUE: begin
          if (bus.mem_ack) begin
            mem_req_q   <= 1'b0;
            req_ack_q   <= grant_q;
            req_rdata_q <= mem_write_q ? '0 : bus.mem_rdata;
            state_q     <= DONE;
          end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
            mem_req_q   <= 1'b0;
            req_ack_q   <= grant_q;
            req_err_q   <= grant_q;
            req_rdata_q <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          lock_q      <= bus.req_lock[owner_q];
          grant_q     <= '0;
          busy_q      <= 1'b0;
          req_rdata_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.req_ack   = req_ack_q;
  assign bus.req_err   = req_err_q;
  assign bus.req_rdata = req_rdata_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cram_port_arbiter.sv
// Self-checking bench for cram_port_arbiter: directed scenarios plus randomized
// transactions predicted by a small arbitration model kept in the bench.
module tb_cram_port_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  cram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int failCount = 0;

  // Arbitration model: next search start, last owner, and whether that owner held its lock.
  int mStart;
  int mLast;
  bit mLock;

  // Observations captured by doTxn.
  int          obsOwner;
  int          obsCycles;
  int          obsReqCycles;
  logic [1:0]  obsGrantIssue;
  logic [1:0]  obsGrantDone;
  logic [1:0]  obsAck;
  logic [1:0]  obsErr;
  logic [15:0] obsRdata;
  logic        obsWrite;
  logic        obsWriteLast;
  logic [21:0] obsAddr;
  logic [15:0] obsWdata;
  logic [1:0]  obsBe;

  function automatic logic bitAt(input logic [1:0] v, input int k);
    return v[k[0]];
  endfunction

  function automatic int modelWinner(input logic [1:0] v);
    if (mLock && bitAt(v, mLast)) return mLast;
    for (int i = 0; i < NUM_REQ; i++)
      if (bitAt(v, (mStart + i) % NUM_REQ)) return (mStart + i) % NUM_REQ;
    return -1;
  endfunction

  task automatic modelReset();
    mStart = 0;
    mLast  = 0;
    mLock  = 1'b0;
  endtask

  task automatic modelGrant(input int w);
    mLast  = w;
    mStart = (w + 1) % NUM_REQ;
  endtask

  task automatic setReq(input int i, input logic v, input logic w, input logic l,
                        input logic [21:0] a, input logic [15:0] d, input logic [1:0] be);
    bus.req_valid[i[0]]          = v;
    bus.req_write[i[0]]          = w;
    bus.req_lock[i[0]]           = l;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
    bus.req_be[i*2 +: 2]         = be;
  endtask

  task automatic clearReqs();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
  endtask

  // Called in the DONE cycle after the next inputs are set; the owner's lock is taken from them.
  task automatic toIdle();
    mLock = bitAt(bus.req_lock, mLast);
    @(negedge clk);
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    modelReset();
  endtask

  // Starts at a negedge in an IDLE cycle; returns at the negedge of the ack cycle.
  task automatic doTxn(input int ackDelay, input logic [15:0] rd);
    @(negedge clk);
    obsGrantIssue = bus.grant;
    obsOwner      = (bus.grant == 2'b01) ? 0 : (bus.grant == 2'b10) ? 1 : -1;
    obsWrite      = bus.mem_write;
    obsAddr       = bus.mem_addr;
    obsWdata      = bus.mem_wdata;
    obsBe         = bus.mem_be;
    obsWriteLast  = 1'b0;
    obsCycles     = -1;
    obsReqCycles  = 0;
    obsAck        = '0;
    obsErr        = '0;
    obsRdata      = 16'hDEAD;
    obsGrantDone  = '0;
    for (int c = 1; c < 40; c++) begin
      if (bus.req_ack !== 2'b00) begin
        obsCycles    = c;
        obsAck       = bus.req_ack;
        obsErr       = bus.req_err;
        obsRdata     = bus.req_rdata;
        obsGrantDone = bus.grant;
        break;
      end
      if (bus.mem_req === 1'b1) begin
        obsReqCycles++;
        obsWriteLast = bus.mem_write;
      end
      if (c == ackDelay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    setReq(0, 1'b1, 1'b1, 1'b1, 22'h155555, 16'h1234, 2'b11);
    setReq(1, 1'b1, 1'b0, 1'b0, 22'h0AAAAA, 16'h4321, 2'b01);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    vecCount++;
    if (bus.mem_req !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    vecCount++;
    if (bus.grant !== 2'b00) begin failCount++; $display("[TB] FAIL reset_grant: got %b expected 00", bus.grant); end
    vecCount++;
    if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    vecCount++;
    if ({bus.req_ack, bus.req_err} !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_ack_err: got %b expected 0000", {bus.req_ack, bus.req_err}); end
    vecCount++;
    if (bus.req_rdata !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_rdata: got %h expected 0000", bus.req_rdata); end
    vecCount++;
    if ({bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 41'h0) begin
      failCount++; $display("[TB] FAIL reset_mem_fields: got %h expected 0", {bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_be});
    end
    clearReqs();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int expW;
    clearReqs();
    setReq(0, 1'b1, 1'b0, 1'b0, 22'h00123, 16'h0000, 2'b00);
    expW = modelWinner(bus.req_valid);
    doTxn(2, 16'hBEEF);
    vecCount++;
    if (obsOwner !== expW) begin failCount++; $display("[TB] FAIL read_owner: got %0d expected %0d", obsOwner, expW); end
    vecCount++;
    if (obsGrantIssue !== 2'b01) begin failCount++; $display("[TB] FAIL read_grant_issue: got %b expected 01", obsGrantIssue); end
    vecCount++;
    if (obsAddr !== 22'h00123 || obsWrite !== 1'b0) begin failCount++; $display("[TB] FAIL read_cmd: got addr %h wr %b expected 000123 0", obsAddr, obsWrite); end
    vecCount++;
    if (obsCycles !== 3) begin failCount++; $display("[TB] FAIL read_latency: got %0d expected 3", obsCycles); end
    vecCount++;
    if (obsReqCycles !== 2) begin failCount++; $display("[TB] FAIL read_mem_req_cycles: got %0d expected 2", obsReqCycles); end
    vecCount++;
    if (obsAck !== 2'b01 || obsErr !== 2'b00) begin failCount++; $display("[TB] FAIL read_ack: got ack %b err %b expected 01 00", obsAck, obsErr); end
    vecCount++;
    if (obsRdata !== 16'hBEEF) begin failCount++; $display("[TB] FAIL read_rdata: got %h expected beef", obsRdata); end
    vecCount++;
    if (obsGrantDone !== 2'b01) begin failCount++; $display("[TB] FAIL read_grant_done: got %b expected 01", obsGrantDone); end
    modelGrant(expW);
    clearReqs();
    toIdle();
    vecCount++;
    if (bus.req_ack !== 2'b00 || bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
      failCount++; $display("[TB] FAIL read_after_done: got ack %b busy %b grant %b expected 00 0 00", bus.req_ack, bus.busy, bus.grant);
    end
  endtask

  task automatic test_round_robin();
    int  expW;
    time lastAck;
    applyReset();
    setReq(0, 1'b1, 1'b0, 1'b0, 22'h000010, 16'h0, 2'b00);
    setReq(1, 1'b1, 1'b0, 1'b0, 22'h000020, 16'h0, 2'b00);
    lastAck = 0;
    for (int i = 0; i < 6; i++) begin
      expW = modelWinner(bus.req_valid);
      doTxn(1, 16'(16'h1111 * (i + 1)));
      vecCount++;
      if (obsOwner !== (i % 2) || obsOwner !== expW) begin failCount++; $display("[TB] FAIL rr_owner[%0d]: got %0d expected %0d", i, obsOwner, i % 2); end
      vecCount++;
      if (obsAck !== 2'(1 << (i % 2)) || obsCycles !== 2) begin
        failCount++; $display("[TB] FAIL rr_ack[%0d]: got ack %b at cycle %0d expected %b at 2", i, obsAck, obsCycles, 2'(1 << (i % 2)));
      end
      vecCount++;
      if (obsRdata !== 16'(16'h1111 * (i + 1))) begin failCount++; $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", i, obsRdata, 16'(16'h1111 * (i + 1))); end
      if (i > 0) begin
        vecCount++;
        if ($time - lastAck != 30) begin failCount++; $display("[TB] FAIL rr_spacing[%0d]: got %0t expected 30", i, $time - lastAck); end
      end
      lastAck = $time;
      modelGrant(expW);
      if (i == 5) clearReqs();
      toIdle();
    end
  endtask

  task automatic test_lock();
    int expOwner;
    applyReset();
    clearReqs();
    setReq(1, 1'b1, 1'b1, 1'b1, 22'h001000, 16'hC0DE, 2'b11);
    for (int i = 0; i < 5; i++) begin
      expOwner = (i < 4) ? 1 : 0;
      doTxn(1, 16'h0F0F);
      vecCount++;
      if (obsOwner !== expOwner) begin failCount++; $display("[TB] FAIL lock_owner[%0d]: got %0d expected %0d", i, obsOwner, expOwner); end
      vecCount++;
      if (obsWrite !== (expOwner == 1)) begin failCount++; $display("[TB] FAIL lock_write[%0d]: got %b expected %b", i, obsWrite, expOwner == 1); end
      modelGrant(expOwner);
      if (i == 0) setReq(0, 1'b1, 1'b0, 1'b0, 22'h002000, 16'h0, 2'b00);
      if (i == 3) bus.req_lock[1] = 1'b0;
      if (i == 4) clearReqs();
      toIdle();
    end
  endtask

  task automatic test_write_byte_enable();
    clearReqs();
    setReq(1, 1'b1, 1'b1, 1'b0, 22'h2AAAA, 16'hA5C3, 2'b10);
    doTxn(3, 16'h1234);
    vecCount++;
    if (obsOwner !== 1 || obsGrantIssue !== 2'b10) begin failCount++; $display("[TB] FAIL wr_owner: got %0d grant %b expected 1 10", obsOwner, obsGrantIssue); end
    vecCount++;
    if ({obsWrite, obsWdata, obsBe} !== {1'b1, 16'hA5C3, 2'b10}) begin
      failCount++; $display("[TB] FAIL wr_cmd: got wr %b data %h be %b expected 1 a5c3 10", obsWrite, obsWdata, obsBe);
    end
    vecCount++;
    if (obsWriteLast !== 1'b1 || obsReqCycles !== 3) begin failCount++; $display("[TB] FAIL wr_hold: got wr %b for %0d cycles expected 1 for 3", obsWriteLast, obsReqCycles); end
    vecCount++;
    if (obsAck !== 2'b10 || obsRdata !== 16'h0000) begin failCount++; $display("[TB] FAIL wr_ack: got ack %b rdata %h expected 10 0000", obsAck, obsRdata); end
    modelGrant(1);
    clearReqs();
    toIdle();
  endtask

  task automatic test_timeout();
    clearReqs();
    setReq(0, 1'b1, 1'b0, 1'b0, 22'h3FFFFF, 16'h0, 2'b00);
    bus.mem_rdata = 16'hFFFF;
    doTxn(0, 16'hFFFF);
    vecCount++;
    if (obsReqCycles !== TIMEOUT) begin failCount++; $display("[TB] FAIL to_mem_req_cycles: got %0d expected %0d", obsReqCycles, TIMEOUT); end
    vecCount++;
    if (obsCycles !== TIMEOUT + 1) begin failCount++; $display("[TB] FAIL to_ack_cycle: got %0d expected %0d", obsCycles, TIMEOUT + 1); end
    vecCount++;
    if (obsAck !== 2'b01 || obsErr !== 2'b01) begin failCount++; $display("[TB] FAIL to_ack_err: got ack %b err %b expected 01 01", obsAck, obsErr); end
    vecCount++;
    if (obsRdata !== 16'h0000) begin failCount++; $display("[TB] FAIL to_rdata: got %h expected 0000", obsRdata); end
    modelGrant(0);
    clearReqs();
    toIdle();
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    vecCount++;
    if ({bus.req_ack, bus.req_err, bus.busy, bus.mem_req} !== 6'b0 || bus.req_rdata !== 16'h0) begin
      failCount++; $display("[TB] FAIL late_ack_ignored: got ack %b err %b busy %b mem_req %b rdata %h expected all 0",
                            bus.req_ack, bus.req_err, bus.busy, bus.mem_req, bus.req_rdata);
    end
  endtask

  task automatic test_reset_mid_issue();
    int expW;
    clearReqs();
    setReq(1, 1'b1, 1'b0, 1'b0, 22'h000777, 16'h0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    vecCount++;
    if (bus.mem_req !== 1'b1 || bus.grant !== 2'b10) begin failCount++; $display("[TB] FAIL mid_issue_active: got mem_req %b grant %b expected 1 10", bus.mem_req, bus.grant); end
    #2 reset_n = 1'b0;
    #1;
    vecCount++;
    if ({bus.mem_req, bus.grant, bus.busy} !== 4'b0000) begin
      failCount++; $display("[TB] FAIL async_reset: got mem_req %b grant %b busy %b expected 0 00 0", bus.mem_req, bus.grant, bus.busy);
    end
    setReq(0, 1'b1, 1'b0, 1'b0, 22'h000555, 16'h0, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    expW = modelWinner(bus.req_valid);
    doTxn(1, 16'h5A5A);
    vecCount++;
    if (obsOwner !== 0 || obsOwner !== expW) begin failCount++; $display("[TB] FAIL post_reset_owner: got %0d expected 0", obsOwner); end
    vecCount++;
    if (obsRdata !== 16'h5A5A || obsAddr !== 22'h000555) begin failCount++; $display("[TB] FAIL post_reset_read: got %h @%h expected 5a5a @000555", obsRdata, obsAddr); end
    modelGrant(expW);
    clearReqs();
    toIdle();
  endtask

  task automatic test_random();
    int          expW;
    int          delay;
    bit          expErr;
    int          expCycles;
    logic        expWrite;
    logic [21:0] expAddr;
    logic [15:0] expWdata;
    logic [1:0]  expBe;
    logic [15:0] rd;
    logic [15:0] expRdata;
    logic [1:0]  expVec;
    applyReset();
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < NUM_REQ; r++)
        setReq(r, 1'($urandom), 1'($urandom), 1'($urandom), 22'($urandom), 16'($urandom), 2'($urandom));
      if (bus.req_valid == 2'b00) bus.req_valid[$urandom_range(0, 1)] = 1'b1;
      if (n > 0) toIdle();
      expW      = modelWinner(bus.req_valid);
      expWrite  = bitAt(bus.req_write, expW);
      expAddr   = bus.req_addr[expW*ADDR_W +: ADDR_W];
      expWdata  = bus.req_wdata[expW*DATA_W +: DATA_W];
      expBe     = bus.req_be[expW*2 +: 2];
      delay     = $urandom_range(0, 9);
      rd        = 16'($urandom);
      expErr    = (delay == 0) || (delay > TIMEOUT);
      expCycles = expErr ? TIMEOUT + 1 : delay + 1;
      expRdata  = (expErr || expWrite) ? 16'h0000 : rd;
      expVec    = 2'(1 << expW);
      doTxn(delay, rd);
      vecCount++;
      if (obsOwner !== expW) begin failCount++; $display("[TB] FAIL rand_owner[%0d]: got %0d expected %0d", n, obsOwner, expW); end
      vecCount++;
      if ({obsWrite, obsAddr, obsWdata, obsBe} !== {expWrite, expAddr, expWdata, expBe}) begin
        failCount++; $display("[TB] FAIL rand_cmd[%0d]: got %b %h %h %b expected %b %h %h %b", n, obsWrite, obsAddr, obsWdata, obsBe, expWrite, expAddr, expWdata, expBe);
      end
      vecCount++;
      if (obsCycles !== expCycles || obsReqCycles !== expCycles - 1) begin
        failCount++; $display("[TB] FAIL rand_timing[%0d]: got ack cycle %0d req cycles %0d expected %0d %0d", n, obsCycles, obsReqCycles, expCycles, expCycles - 1);
      end
      vecCount++;
      if (obsAck !== expVec || obsErr !== (expErr ? expVec : 2'b00)) begin
        failCount++; $display("[TB] FAIL rand_ack[%0d]: got ack %b err %b expected %b %b", n, obsAck, obsErr, expVec, expErr ? expVec : 2'b00);
      end
      vecCount++;
      if (obsRdata !== expRdata) begin failCount++; $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", n, obsRdata, expRdata); end
      modelGrant(expW);
    end
    clearReqs();
    toIdle();
  endtask

  initial begin
    clearReqs();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    modelReset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_write_byte_enable();
    test_timeout();
    test_reset_mid_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] time limit");
  end
endmodule
